vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing source and pixel output stage for the VGA display path.
//  - Generates x/y pixel coordinates that drive the text overlay renderers.
//  - Takes back each renderer's registered overlay_active bit.
//  - Emits hsync/vsync/RGB, with sync and blanking delayed to line up with the
//    renderer pipeline. It is the coordinate producer and pixel consumer
//    (opposite end of the overlay interface).
// PARAMETERS
//  H_ACTIVE    640  visible pixels per line
//  H_FP        16   horizontal front porch (pixels)
//  H_SYNC      96   hsync width (pixels)
//  H_BP        48   horizontal back porch (pixels)
//  V_ACTIVE    480  visible lines per frame
//  V_FP        10   vertical front porch (lines)
//  V_SYNC      2    vsync width (lines)
//  V_BP        33   vertical back porch (lines)
//  SYNC_POL    0    sync active level (0 = active-low)
//  PIPE_DELAY  1    overlay renderer latency in clocks (>=1)
//  FRAME_W     8    frame counter width
// PORTS
//  clk             in   1        pixel clock (25.175 MHz nominal)
//  rst             in   1        synchronous, active-high reset
//  x               out  10       horizontal counter, 0..H_TOTAL-1
//  y               out  10       vertical counter, 0..V_TOTAL-1
//  overlay_active  in   1        renderer output; valid PIPE_DELAY clks after x/y
//  fg_rgb          in   6        RRGGBB colour when overlay_active=1
//  bg_rgb          in   6        RRGGBB colour when overlay_active=0
//  rgb_out         out  6        registered pixel colour
//  hsync           out  1        registered horizontal sync
//  vsync           out  1        registered vertical sync
//  display_on      out  1        registered visible-area flag, aligned with rgb_out
//  frame_tick      out  1        1-clk pulse on frame wrap
//  frame_count     out  FRAME_W  frames since reset, modulo 2^FRAME_W
// BEHAVIOUR
//  - Totals: H_TOTAL = sum of the H_* params (800); V_TOTAL = sum of V_* (525).
//  - x increments every clk; x = H_TOTAL-1 wraps x to 0 and increments y.
//  - y = V_TOTAL-1 together with that x wrap sets y to 0.
//  - x and y are the counter registers themselves (zero latency).
//  - Raw terms, evaluated at stage 0 from the counters:
//      vis = (x < H_ACTIVE) && (y < V_ACTIVE)
//      hs  = x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]   (656..751)
//      vs  = y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]   (490..491)
//  - vis, hs and vs pass through a PIPE_DELAY-deep shift register, so they
//    are aligned with overlay_active.
//  - Output register, one further clk:
//      rgb_out    <= vis_d ? (overlay_active ? fg_rgb : bg_rgb) : 6'h00
//      hsync      <= hs_d ? SYNC_POL : ~SYNC_POL    (vsync likewise)
//      display_on <= vis_d
//  - Total latency from counter value to pins = PIPE_DELAY+1 clks (2 by default).
//  - frame_tick = 1 in the clk where the counters move (H_TOTAL-1, V_TOTAL-1)
//    -> (0,0). On that same edge frame_count increments, wrapping 2^FRAME_W-1 -> 0.
//  - Reset (valid at any point, mid-line or mid-frame), values after the edge:
//      x = 0, y = 0, frame_count = 0, frame_tick = 0, rgb_out = 0,
//      display_on = 0, hsync = vsync = ~SYNC_POL.
//    Delay-line contents are cleared to vis = 0 and syncs inactive.
//    Counting restarts at (0,0) on the first clk after rst deasserts.
//  - fg_rgb and bg_rgb are sampled in the output-register cycle; they are not
//    delayed.
//  - overlay_active is ignored while vis_d = 0.
// STRUCTURE
//  - Timing localparams (H_TOTAL, V_TOTAL, sync start/end) and the 6-bit
//    colour constants live in the shared vga_params package/header.
//  - One sub-module, sync_delay: a parameterised WIDTH x DEPTH shift register
//    with synchronous reset to a given value. It is used for {vis, hs, vs}.
//  - Counters, frame logic and the output register are in this module.
// TESTING
//  - Release reset: x=0,y=0 on first clk; x reaches 799 then 0 with y=1
//    exactly 800 clks after release.
//  - hsync: first low output 2 clks after x==656; low for exactly 96 clks;
//    high again 2 clks after x==752.
//  - vsync: low for exactly 2*800 clks beginning 2 clks after (x=0, y=490);
//    frame period = 420000 clks.
//  - Tie overlay_active=1, fg=6'h3F, bg=6'h01:
//    * rgb_out=3F for x in 0..639 of rows 0..479, seen 2 clks later;
//    * rgb_out=00 2 clks after x==640 and throughout rows 480..524.
//  - Toggle overlay_active with x[0], driven one clk late: rgb_out alternates
//    3F/01 with no skew at the x=0 and x=639 edges.
//  - frame_tick once per 420000 clks; with FRAME_W=2, frame_count goes
//    0,1,2,3,0 over 4 frames.
//  - rst asserted at (x=300, y=200): the next clk shows x=0, y=0, rgb_out=0,
//    hsync=vsync=1, frame_count=0.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared raster timing defaults, colour constants and a small range helper
// for the VGA timing generator and its overlay interface.
package vga_timing_gen_pkg;

    localparam int COORD_W = 10;
    localparam int RGB_W   = 6;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam logic [RGB_W-1:0] RGB_BLACK = 6'h00;
    localparam logic [RGB_W-1:0] RGB_WHITE = 6'h3F;

    function automatic logic in_span(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Overlay interface: the timing generator (master) publishes x/y, the
// renderer (slave) answers with overlay_active and the two candidate colours.
interface vga_timing_gen_if;
    import vga_timing_gen_pkg::*;

    // No handshake: x/y are valid every clock; overlay_active must be the
    // renderer's answer for the x/y presented PIPE_DELAY clocks earlier.
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               overlay_active;
    logic [RGB_W-1:0]   fg_rgb;
    logic [RGB_W-1:0]   bg_rgb;

    modport master (output x, y, input overlay_active, fg_rgb, bg_rgb);
    modport slave  (input x, y, output overlay_active, fg_rgb, bg_rgb);

endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// WIDTH x DEPTH shift register with synchronous reset to RST_VAL; keeps the
// raster flags in step with the overlay renderer pipeline.
module sync_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= RST_VAL;
            end
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, frame counter and registered pixel/sync output stage,
// with sync and blanking delayed to match the overlay renderer latency.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit SYNC_POL   = 1'b0,
    parameter int PIPE_DELAY = 1,
    parameter int FRAME_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    vga_timing_gen_if.master   ovl,
    output logic [RGB_W-1:0]   rgb_out,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               frame_tick,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [FRAME_W-1:0] r_frame_count;
    logic [RGB_W-1:0]   r_rgb;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_display_on;

    logic       w_x_wrap;
    logic       w_y_wrap;
    logic [2:0] w_stage0;
    logic [2:0] w_stage_d;
    logic       w_vis_d;
    logic       w_hs_d;
    logic       w_vs_d;

    assign w_x_wrap = (r_x == H_LAST);
    assign w_y_wrap = (r_y == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_x_wrap) begin
            r_x <= '0;
            r_y <= w_y_wrap ? '0 : r_y + COORD_W'(1);
        end else begin
            r_x <= r_x + COORD_W'(1);
        end
    end

    // The tick marks the last pixel of the frame; the count moves on the same edge as the counters.
    assign frame_tick = w_x_wrap & w_y_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_count <= '0;
        end else if (frame_tick) begin
            r_frame_count <= r_frame_count + FRAME_W'(1);
        end
    end

    // Stage-0 flags are "asserted" meanings; polarity is applied at the pins.
    assign w_stage0 = {(r_x < H_VIS) && (r_y < V_VIS),
                       in_span(r_x, HS_START, HS_END),
                       in_span(r_y, VS_START, VS_END)};

    sync_delay #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (3'b000)
    ) u_sync_delay (
        .clk (clk),
        .rst (rst),
        .i_d (w_stage0),
        .o_q (w_stage_d)
    );

    assign {w_vis_d, w_hs_d, w_vs_d} = w_stage_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb        <= RGB_BLACK;
            r_hsync      <= ~SYNC_POL;
            r_vsync      <= ~SYNC_POL;
            r_display_on <= 1'b0;
        end else begin
            r_rgb        <= w_vis_d ? (ovl.overlay_active ? ovl.fg_rgb : ovl.bg_rgb) : RGB_BLACK;
            r_hsync      <= w_hs_d ? SYNC_POL : ~SYNC_POL;
            r_vsync      <= w_vs_d ? SYNC_POL : ~SYNC_POL;
            r_display_on <= w_vis_d;
        end
    end

    assign ovl.x       = r_x;
    assign ovl.y       = r_y;
    assign rgb_out     = r_rgb;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign display_on  = r_display_on;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster (16 x 10, 160-clock
// frames) so several frames and a mid-frame reset fit in a short run.
module tb_vga_timing_gen;
    import vga_timing_gen_pkg::*;

    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int FW       = 2;
    localparam int H_TOT    = 16;
    localparam int V_TOT    = 10;
    localparam int FRAME    = 160;
    localparam int HS_LO    = 10;
    localparam int HS_HI    = 12;
    localparam int VS_LO    = 7;
    localparam int VS_HI    = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if ovl_if();

    logic [RGB_W-1:0] rgb_out;
    logic             hsync;
    logic             vsync;
    logic             display_on;
    logic             frame_tick;
    logic [FW-1:0]    frame_count;

    vga_timing_gen #(
        .H_ACTIVE   (H_ACTIVE),
        .H_FP       (H_FP),
        .H_SYNC     (H_SYNC),
        .H_BP       (H_BP),
        .V_ACTIVE   (V_ACTIVE),
        .V_FP       (V_FP),
        .V_SYNC     (V_SYNC),
        .V_BP       (V_BP),
        .SYNC_POL   (1'b0),
        .PIPE_DELAY (1),
        .FRAME_W    (FW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ovl         (ovl_if.master),
        .rgb_out     (rgb_out),
        .hsync       (hsync),
        .vsync       (vsync),
        .display_on  (display_on),
        .frame_tick  (frame_tick),
        .frame_count (frame_count)
    );

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    int            k        = 0;
    logic [FW-1:0] exp_q[$];

    typedef struct {
        int         k;
        int         x;
        int         y;
        logic [5:0] rgb;
        logic       hs;
        logic       vs;
        logic       don;
        logic       tick;
        int         fc;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, obs, exp_v);
        end
    endtask

    task automatic add_vec(input int vk, input int vx, input int vy, input logic [5:0] vrgb,
                           input logic vhs, input logic vvs, input logic vdon,
                           input logic vtick, input int vfc);
        vec_t v;
        v.k = vk; v.x = vx; v.y = vy; v.rgb = vrgb; v.hs = vhs; v.vs = vvs;
        v.don = vdon; v.tick = vtick; v.fc = vfc;
        vecs.push_back(v);
    endtask

    // Renderer answer for raster index c: even frames hold overlay on, odd frames follow x[0].
    function automatic logic ovl_f(input int c);
        if (c < 0) return 1'b0;
        if (((c / FRAME) % 2) == 0) return 1'b1;
        return ((c % H_TOT) % 2) == 1;
    endfunction

    task automatic check_model();
        int         c2;
        int         x2;
        int         y2;
        logic       vis;
        logic [5:0] e_rgb;
        logic       e_hs;
        logic       e_vs;
        vis   = 1'b0;
        e_rgb = 6'h00;
        e_hs  = 1'b1;
        e_vs  = 1'b1;
        if (k >= 2) begin
            c2    = k - 2;
            x2    = c2 % H_TOT;
            y2    = (c2 / H_TOT) % V_TOT;
            vis   = (x2 < H_ACTIVE) && (y2 < V_ACTIVE);
            e_hs  = !((x2 >= HS_LO) && (x2 <= HS_HI));
            e_vs  = !((y2 >= VS_LO) && (y2 <= VS_HI));
            e_rgb = vis ? (ovl_f(c2) ? 6'h3F : 6'h01) : 6'h00;
        end
        check("m_x",    32'(ovl_if.x),    32'(k % H_TOT));
        check("m_y",    32'(ovl_if.y),    32'((k / H_TOT) % V_TOT));
        check("m_rgb",  32'(rgb_out),     32'(e_rgb));
        check("m_hs",   32'(hsync),       32'(e_hs));
        check("m_vs",   32'(vsync),       32'(e_vs));
        check("m_don",  32'(display_on),  32'(vis));
        check("m_tick", 32'(frame_tick),  32'((k % FRAME) == FRAME - 1));
        check("m_fc",   32'(frame_count), 32'((k / FRAME) % 4));
    endtask

    task automatic check_vecs();
        foreach (vecs[i]) begin
            if (vecs[i].k == k) begin
                check("v_x",    32'(ovl_if.x),    32'(vecs[i].x));
                check("v_y",    32'(ovl_if.y),    32'(vecs[i].y));
                check("v_rgb",  32'(rgb_out),     32'(vecs[i].rgb));
                check("v_hs",   32'(hsync),       32'(vecs[i].hs));
                check("v_vs",   32'(vsync),       32'(vecs[i].vs));
                check("v_don",  32'(display_on),  32'(vecs[i].don));
                check("v_tick", 32'(frame_tick),  32'(vecs[i].tick));
                check("v_fc",   32'(frame_count), 32'(vecs[i].fc));
            end
        end
    endtask

    // ---------------- driver ----------------
    // Entered on a negedge with rst high; releases reset and runs n_cyc clocks.
    task automatic sweep(input int n_cyc, input int exp_ticks);
        int   hs_run    = 0;
        int   vs_run    = 0;
        int   last_tick = -1;
        int   n_ticks   = 0;
        logic fc_due    = 1'b0;
        k = 0;
        check_model();
        check_vecs();
        rst = 1'b0;
        ovl_if.overlay_active = ovl_f(-1);
        for (int i = 1; i <= n_cyc; i++) begin
            @(posedge clk);
            k = i;
            @(negedge clk);
            check_model();
            check_vecs();
            if (fc_due) begin
                if (exp_q.size() > 0) check("fc_seq", 32'(frame_count), 32'(exp_q.pop_front()));
                else check("fc_seq_extra", 32'(frame_count), 32'hFFFF_FFFF);
                fc_due = 1'b0;
            end
            if (!hsync) hs_run++;
            else if (hs_run > 0) begin
                check("hs_width", 32'(hs_run), 32'(H_SYNC));
                hs_run = 0;
            end
            if (!vsync) vs_run++;
            else if (vs_run > 0) begin
                check("vs_width", 32'(vs_run), 32'(V_SYNC * H_TOT));
                vs_run = 0;
            end
            if (frame_tick) begin
                n_ticks++;
                if (last_tick >= 0) check("frame_period", 32'(k - last_tick), 32'(FRAME));
                last_tick = k;
                fc_due    = 1'b1;
            end
            ovl_if.overlay_active = ovl_f(k - 1);
        end
        check("tick_count", 32'(n_ticks), 32'(exp_ticks));
    endtask

    initial begin
        ovl_if.overlay_active = 1'b0;
        ovl_if.fg_rgb         = 6'h3F;
        ovl_if.bg_rgb         = 6'h01;

        //       k    x   y   rgb    hs vs don tk fc
        add_vec(  0,  0,  0, 6'h00, 1, 1, 0, 0, 0);
        add_vec(  1,  1,  0, 6'h00, 1, 1, 0, 0, 0);
        add_vec(  2,  2,  0, 6'h3F, 1, 1, 1, 0, 0);
        add_vec(  9,  9,  0, 6'h3F, 1, 1, 1, 0, 0);
        add_vec( 10, 10,  0, 6'h00, 1, 1, 0, 0, 0);
        add_vec( 12, 12,  0, 6'h00, 0, 1, 0, 0, 0);
        add_vec( 14, 14,  0, 6'h00, 0, 1, 0, 0, 0);
        add_vec( 15, 15,  0, 6'h00, 1, 1, 0, 0, 0);
        add_vec( 16,  0,  1, 6'h00, 1, 1, 0, 0, 0);
        add_vec( 18,  2,  1, 6'h3F, 1, 1, 1, 0, 0);
        add_vec(113,  1,  7, 6'h00, 1, 1, 0, 0, 0);
        add_vec(114,  2,  7, 6'h00, 1, 0, 0, 0, 0);
        add_vec(145,  1,  9, 6'h00, 1, 0, 0, 0, 0);
        add_vec(146,  2,  9, 6'h00, 1, 1, 0, 0, 0);
        add_vec(159, 15,  9, 6'h00, 1, 1, 0, 1, 0);
        add_vec(160,  0,  0, 6'h00, 1, 1, 0, 0, 1);
        add_vec(162,  2,  0, 6'h01, 1, 1, 1, 0, 1);
        add_vec(163,  3,  0, 6'h3F, 1, 1, 1, 0, 1);
        add_vec(169,  9,  0, 6'h3F, 1, 1, 1, 0, 1);
        add_vec(170, 10,  0, 6'h00, 1, 1, 0, 0, 1);
        add_vec(322,  2,  0, 6'h3F, 1, 1, 1, 0, 2);
        add_vec(480,  0,  0, 6'h00, 1, 1, 0, 0, 3);
        add_vec(640,  0,  0, 6'h00, 1, 1, 0, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);

        // Four full frames plus 53 clocks: ends at x=5, y=3 of frame 4.
        exp_q = '{2'd1, 2'd2, 2'd3, 2'd0};
        sweep(4 * FRAME + 53, 4);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("pre_rst_x", 32'(ovl_if.x), 32'd5);
        check("pre_rst_y", 32'(ovl_if.y), 32'd3);

        // Mid-frame reset: the k=0 checks of the next sweep cover the reset values.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_q = '{2'd1};
        sweep(200, 1);
        check("exp_q_drained2", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
